pcm_to_pdm: RTL

//   Second-order delta-sigma modulator: converts signed PCM audio samples into a 1-bit PDM stream.
//   It is the playback-side counterpart of pdm_to_pcm (same OSR, same clock) and feeds the speaker/amp PDM pin.
//   A sample-period counter paces consumption of samples delivered over a valid/ready handshake.
//   A two-entry buffer (current + pending) absorbs producer jitter.

---
 rtl/pcm_to_pdm.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pcm_to_pdm.sv
// Second-order delta-sigma modulator: signed PCM in, 1-bit PDM out.
// Ports: clk, rst (async low), en, pcm_in/pcm_valid/pcm_ready, sample_tick, underrun, pdm_out.
module pcm_to_pdm #(
  parameter int WIDTH = 16,
  parameter int OSR   = 100,
  parameter int ACC_W = 24,
  parameter int CLAMP = 29491
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] pcm_in,
  input  logic                    pcm_valid,
  output logic                    pcm_ready,
  output logic                    sample_tick,
  output logic                    underrun,
  output logic                    pdm_out
);

  localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int SW = ACC_W + 2;

  localparam logic [CW-1:0] LAST = CW'(OSR - 1);

  localparam logic signed [SW-1:0] FS_P = SW'(2 ** (WIDTH - 1));
  localparam logic signed [SW-1:0] FS_N = -FS_P;
  localparam logic signed [SW-1:0] A_MAX = SW'(2 ** (ACC_W - 1) - 1);
  localparam logic signed [SW-1:0] A_MIN = -A_MAX - 1;

  localparam logic signed [WIDTH-1:0] CL_P = WIDTH'(CLAMP);
  localparam logic signed [WIDTH-1:0] CL_N = -CL_P;

  function automatic logic signed [ACC_W-1:0] sat_acc(
    input logic signed [SW-1:0] v
  );
    if (v > A_MAX) return A_MAX[ACC_W-1:0];
    if (v < A_MIN) return A_MIN[ACC_W-1:0];
    return v[ACC_W-1:0];
  endfunction

  logic [1:0] rs_q;
  logic       run;

  logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
  logic          en_q, en_d;
  logic          full_q, full_d;
  logic          tick_q, tick_d;
  logic          ur_q, ur_d;
  logic          pdm_q, pdm_d;

  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic signed [WIDTH-1:0] pend_q, pend_d;
  logic signed [WIDTH-1:0] pcm_sat;

  logic signed [ACC_W-1:0] i1_q, i1_d;
  logic signed [ACC_W-1:0] i2_q, i2_d;

  logic signed [SW-1:0] x_w, fb_w;
  logic signed [SW-1:0] i1_w, i2_w;
  logic signed [SW-1:0] s1, s2;

  logic tick_c, accept;

  // Release is synchronised; assertion stays asynchronous.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rs_q <= 2'b00;
    else      rs_q <= {rs_q[0], 1'b1};
  end

  assign run = rs_q[1];

  always_comb begin
    if (pcm_in > CL_P)      pcm_sat = CL_P;
    else if (pcm_in < CL_N) pcm_sat = CL_N;
    else                    pcm_sat = pcm_in;

    // A fresh enable behaves as if the counter sat at zero.
    cnt_eff = en_q ? cnt_q : '0;
    tick_c  = en & (cnt_eff == LAST);
    accept  = pcm_valid & ~full_q;

    x_w  = {{(SW-WIDTH){cur_q[WIDTH-1]}}, cur_q};
    fb_w = pdm_q ? FS_P : FS_N;
    i1_w = {{2{i1_q[ACC_W-1]}}, i1_q};
    i2_w = {{2{i2_q[ACC_W-1]}}, i2_q};
    s1   = i1_w + x_w - fb_w;
    s2   = i2_w + i1_w - fb_w;

    cnt_d  = cnt_q;
    en_d   = en;
    cur_d  = cur_q;
    pend_d = pend_q;
    full_d = full_q;
    tick_d = tick_c;
    ur_d   = tick_c & ~full_q;

    if (en) begin
      cnt_d = tick_c ? '0 : cnt_eff + 1'b1;
    end

    if (tick_c && full_q) begin
      cur_d  = pend_q;
      full_d = 1'b0;
    end else if (accept) begin
      pend_d = pcm_sat;
      full_d = 1'b1;
    end

    if (en) begin
      i1_d  = sat_acc(s1);
      i2_d  = sat_acc(s2);
      pdm_d = ~i2_d[ACC_W-1];
    end else begin
      // Idle: clear loop, emit zero-mean square wave.
      i1_d  = '0;
      i2_d  = '0;
      pdm_d = ~pdm_q;
    end

    if (!run) begin
      cnt_d  = '0;
      en_d   = 1'b0;
      cur_d  = '0;
      pend_d = '0;
      full_d = 1'b0;
      tick_d = 1'b0;
      ur_d   = 1'b0;
      i1_d   = '0;
      i2_d   = '0;
      pdm_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      en_q   <= 1'b0;
      cur_q  <= '0;
      pend_q <= '0;
      full_q <= 1'b0;
      tick_q <= 1'b0;
      ur_q   <= 1'b0;
      i1_q   <= '0;
      i2_q   <= '0;
      pdm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      cur_q  <= cur_d;
      pend_q <= pend_d;
      full_q <= full_d;
      tick_q <= tick_d;
      ur_q   <= ur_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      pdm_q  <= pdm_d;
    end
  end

  assign pcm_ready   = ~full_q;
  assign sample_tick = tick_q;
  assign underrun    = ur_q;
  assign pdm_out     = pdm_q;

endmodule
